// File: rtl/mc_control.sv
// Multicycle control FSM for the 16-bit RISC core.
// Sequences fetch, decode, execute, memory and writeback steps for one
// instruction at a time, stalls on the memory ready handshake, and counts
// retired instructions. Datapath controls are decoded from the state register,
// gated by the handshake inputs, and forced low while reset is asserted.
module mc_control #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   opcode,
  input  logic         zero,
  input  logic         mem_ready,
  output logic         memread,
  output logic         memwrite,
  output logic         iord,
  output logic         irwrite,
  output logic         pcen,
  output logic [1:0]   pcsrc,
  output logic         alusrca,
  output logic [1:0]   alusrcb,
  output logic [1:0]   aluop,
  output logic         regwrite,
  output logic         regdst,
  output logic         memtoreg,
  output logic         halted,
  output logic [n-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    IEXEC   = 4'd9,
    IWB     = 4'd10,
    JUMP    = 4'd11,
    HALT    = 4'd12
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0001;
  localparam logic [3:0] OP_SW    = 4'b0010;
  localparam logic [3:0] OP_BEQ   = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_SLTI  = 4'b0101;
  localparam logic [3:0] OP_J     = 4'b0110;

  state_t       state_r;
  logic [n-1:0] instret_r;
  logic         pcwrite_s;
  logic         branch_s;
  logic         retire_s;

  assign instret = instret_r;
  // The PC loads on an unconditional write or on a taken branch.
  assign pcen    = pcwrite_s | (branch_s & zero);

  // Flags the cycle in which the current instruction finishes and FETCH follows.
  always_comb begin
    retire_s = 1'b0;
    case (state_r)
      MEMWB, ALUWB, BRANCH, IWB, JUMP: retire_s = 1'b1;
      MEMWR:                           retire_s = mem_ready;
      default:                         retire_s = 1'b0;
    endcase
  end

  // State register and retired-instruction counter; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= FETCH;
      instret_r <= {n{1'b0}};
    end else begin
      if (retire_s) begin
        instret_r <= instret_r + {{(n-1){1'b0}}, 1'b1};
      end else begin
        instret_r <= instret_r;
      end
      case (state_r)
        FETCH:   state_r <= mem_ready ? DECODE : FETCH;
        DECODE: begin
          case (opcode)
            OP_RTYPE:        state_r <= EXECUTE;
            OP_LW, OP_SW:    state_r <= MEMADR;
            OP_BEQ:          state_r <= BRANCH;
            OP_ADDI, OP_SLTI: state_r <= IEXEC;
            OP_J:            state_r <= JUMP;
            default:         state_r <= HALT;
          endcase
        end
        MEMADR:  state_r <= (opcode == OP_SW) ? MEMWR : MEMRD;
        MEMRD:   state_r <= mem_ready ? MEMWB : MEMRD;
        MEMWB:   state_r <= FETCH;
        MEMWR:   state_r <= mem_ready ? FETCH : MEMWR;
        EXECUTE: state_r <= ALUWB;
        ALUWB:   state_r <= FETCH;
        BRANCH:  state_r <= FETCH;
        IEXEC:   state_r <= IWB;
        IWB:     state_r <= FETCH;
        JUMP:    state_r <= FETCH;
        HALT:    state_r <= HALT;
        // Unreachable encodings park safely, like an illegal opcode.
        default: state_r <= HALT;
      endcase
    end
  end

  // Decodes every datapath control from the current state; all low under reset.
  always_comb begin
    memread   = 1'b0;
    memwrite  = 1'b0;
    iord      = 1'b0;
    irwrite   = 1'b0;
    pcwrite_s = 1'b0;
    branch_s  = 1'b0;
    pcsrc     = 2'b00;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    aluop     = 2'b00;
    regwrite  = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    halted    = 1'b0;
    if (reset) begin
      // Reset masks all controls, abandoning any access in progress.
      halted = 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          memread   = 1'b1;
          alusrcb   = 2'b01;
          aluop     = 2'b11;
          // IR load and PC increment pulse only in the cycle memory completes.
          irwrite   = mem_ready;
          pcwrite_s = mem_ready;
        end
        DECODE: begin
          alusrcb = 2'b11;
          aluop   = 2'b11;
        end
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          aluop   = 2'b11;
        end
        MEMRD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        MEMWR: begin
          memwrite = 1'b1;
          iord     = 1'b1;
        end
        EXECUTE: begin
          alusrca = 1'b1;
          aluop   = 2'b00;
        end
        ALUWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        BRANCH: begin
          alusrca  = 1'b1;
          aluop    = 2'b10;
          branch_s = 1'b1;
          pcsrc    = 2'b01;
        end
        IEXEC: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          aluop   = (opcode == OP_SLTI) ? 2'b01 : 2'b11;
        end
        IWB: begin
          regwrite = 1'b1;
        end
        JUMP: begin
          pcwrite_s = 1'b1;
          pcsrc     = 2'b10;
        end
        HALT: begin
          halted = 1'b1;
        end
        default: begin
          halted = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed + randomized bench for mc_control. A reference model describes each
// instruction as the list of steps it must take (with stall cycles inserted)
// and the controls each step must show, plus a retired-instruction count.
module tb_mc_control;

  logic        clk;
  logic        reset;
  logic [3:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        memread, memwrite, iord, irwrite, pcen;
  logic [1:0]  pcsrc, alusrcb, aluop;
  logic        alusrca, regwrite, regdst, memtoreg, halted;
  logic [15:0] instret;

  int          n_eval;
  int          n_fail;
  logic [15:0] exp_instret;
  logic [15:0] obs;

  mc_control #(.n(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .pcen(pcen), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .halted(halted), .instret(instret)
  );

  assign obs = {memread, memwrite, iord, irwrite, pcen, pcsrc, alusrca,
                alusrcb, aluop, regwrite, regdst, memtoreg, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic rb();
    logic [31:0] r;
    r = $urandom;
    return r[0];
  endfunction

  // Packs an expected control set in the same order as obs.
  function automatic logic [15:0] mk(input logic mr, input logic mw, input logic io,
                                     input logic irw, input logic pe, input logic [1:0] ps,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic rw,
                                     input logic rd, input logic mtr, input logic h);
    return {mr, mw, io, irw, pe, ps, asa, asb, aop, rw, rd, mtr, h};
  endfunction

  // One clock cycle: drive inputs, check controls mid-cycle, advance.
  task automatic cyc(input logic mr, input logic z, input logic [15:0] e, input string tag);
    mem_ready = mr;
    zero      = z;
    @(negedge clk);
    n_eval++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_instret(input string tag);
    n_eval++;
    assert (instret === exp_instret) else begin
      n_fail++;
      $error("FAIL %s: instret observed %h expected %h", tag, instret, exp_instret);
    end
  endtask

  task automatic fetch_decode(input int fs);
    for (int k = 0; k < fs; k++)
      cyc(1'b0, rb(), mk(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b11,1'b0,1'b0,1'b0,1'b0), "fetch_stall");
    cyc(1'b1, rb(), mk(1'b1,1'b0,1'b0,1'b1,1'b1,2'b00,1'b0,2'b01,2'b11,1'b0,1'b0,1'b0,1'b0), "fetch_ready");
    cyc(rb(), rb(), mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,2'b11,1'b0,1'b0,1'b0,1'b0), "decode");
  endtask

  // Runs one legal instruction: fs fetch stalls, ms memory stalls, z = zero in BRANCH.
  task automatic run_instr(input logic [3:0] op, input logic z, input int fs, input int ms);
    chk_instret("instret_before");
    opcode = op;
    fetch_decode(fs);
    case (op)
      4'd0: begin
        cyc(rb(), rb(), mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0), "execute");
        cyc(rb(), rb(), mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b1,1'b0,1'b0), "aluwb");
      end
      4'd1, 4'd2: begin
        cyc(rb(), rb(), mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,2'b11,1'b0,1'b0,1'b0,1'b0), "memadr");
        for (int k = 0; k <= ms; k++)
          cyc((k == ms), rb(), mk((op == 4'd1), (op == 4'd2), 1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0), "mem_access");
        if (op == 4'd1)
          cyc(rb(), rb(), mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0,1'b1,1'b0), "memwb");
      end
      4'd3: cyc(rb(), z, mk(1'b0,1'b0,1'b0,1'b0,z,2'b01,1'b1,2'b00,2'b10,1'b0,1'b0,1'b0,1'b0), "branch");
      4'd4, 4'd5: begin
        cyc(rb(), rb(), mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,
                           (op == 4'd5) ? 2'b01 : 2'b11,1'b0,1'b0,1'b0,1'b0), "iexec");
        cyc(rb(), rb(), mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0), "iwb");
      end
      4'd6: cyc(rb(), rb(), mk(1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0), "jump");
      default: cyc(rb(), rb(), 16'h0000, "unexpected_op");
    endcase
    exp_instret = exp_instret + 16'd1;
  endtask

  initial begin
    n_eval      = 0;
    n_fail      = 0;
    exp_instret = 16'h0000;
    reset       = 1'b1;
    opcode      = 4'h0;
    zero        = 1'b0;
    mem_ready   = 1'b0;
    @(posedge clk);
    #1;
    // Reset: every output low regardless of inputs.
    cyc(1'b1, 1'b1, 16'h0000, "reset_outputs");
    cyc(1'b1, 1'b1, 16'h0000, "reset_outputs2");
    reset = 1'b0;

    // R-type with mem_ready held high, then lw with 3 read stalls.
    run_instr(4'd0, 1'b0, 0, 0);
    chk_instret("rtype_retired");
    run_instr(4'd1, 1'b0, 0, 3);
    // beq taken then not taken.
    run_instr(4'd3, 1'b1, 0, 0);
    run_instr(4'd3, 1'b0, 0, 0);
    // slti then addi, then sw with stalls on both fetch and write.
    run_instr(4'd5, 1'b0, 0, 0);
    run_instr(4'd4, 1'b0, 0, 0);
    run_instr(4'd2, 1'b0, 2, 2);
    run_instr(4'd6, 1'b0, 1, 0);

    // Randomized legal instruction stream.
    for (int i = 0; i < 40; i++)
      run_instr(4'($urandom_range(0, 6)), rb(), $urandom_range(0, 2), $urandom_range(0, 3));
    chk_instret("random_stream");

    // Illegal opcode: HALT for 20 cycles, counter frozen, then reset recovers.
    opcode = 4'hF;
    fetch_decode(0);
    for (int k = 0; k < 20; k++)
      cyc(rb(), rb(), mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b1), "halt");
    chk_instret("halt_instret_frozen");
    reset = 1'b1;
    cyc(rb(), rb(), 16'h0000, "halt_reset_outputs");
    reset = 1'b0;
    exp_instret = 16'h0000;
    chk_instret("halt_reset_instret");
    run_instr(4'd4, 1'b0, 0, 0);

    // Reset during a stalled store: strobe drops, next state is FETCH.
    chk_instret("sw_abort_before");
    opcode = 4'd2;
    fetch_decode(0);
    cyc(rb(), rb(), mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,2'b11,1'b0,1'b0,1'b0,1'b0), "abort_memadr");
    cyc(1'b0, rb(), mk(1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0), "abort_memwr_stall");
    reset = 1'b1;
    cyc(1'b0, rb(), 16'h0000, "abort_reset_outputs");
    reset = 1'b0;
    exp_instret = 16'h0000;
    cyc(1'b0, rb(), mk(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b11,1'b0,1'b0,1'b0,1'b0), "abort_next_fetch");
    chk_instret("abort_instret");

    // Counter wrap: preload 0xFFFF while in FETCH, retire one jump.
    force dut.instret_r = 16'hFFFF;
    #1;
    release dut.instret_r;
    exp_instret = 16'hFFFF;
    run_instr(4'd6, 1'b0, 0, 0);
    chk_instret("instret_wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle control FSM for the 16-bit RISC core. It sequences the shared ALU, register file, instruction register and unified memory through fetch, decode, execute, memory and writeback steps, one instruction at a time. It drives the 2-bit `aluop` code that the ALU decoder expands into `alucontrol`, and stalls on a memory ready handshake. It sits between the instruction register's opcode field and every datapath enable.

## Interface
Parameters:
- `n`, 16: datapath width; used only for the retired-instruction counter width.

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  4  instruction bits [15:12] from the IR; stable from DECODE onward.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory has completed the current read or write this cycle.
- `memread`, `memwrite`  out  1  memory strobes.
- `iord`  out  1  memory address source: 0 = PC, 1 = ALUOut.
- `irwrite`  out  1  load the IR.
- `pcen`  out  1  PC load: `pcwrite | (branch & zero)`.
- `pcsrc`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alusrca`  out  1  ALU A input: 0 = PC, 1 = register A.
- `alusrcb`  out  2  ALU B input: 00 = register B, 01 = constant 2, 10 = sign-extended immediate, 11 = immediate shifted left by 1.
- `aluop`  out  2  ALU op class: 00 = R-type (use funct), 11 = add, 10 = sub, 01 = slt.
- `regwrite`, `regdst`, `memtoreg`  out  1  register file write, destination select (1 = rd), and write-data select (1 = MDR).
- `halted`  out  1  an illegal opcode was decoded.
- `instret`  out  n  count of retired instructions.

## Operation
Opcodes: 0000 R-type, 0001 lw, 0010 sw, 0011 beq, 0100 addi, 0101 slti, 0110 j. All others are illegal.

Outputs are decoded from the state. Every output not listed for a state is 0.

States and transitions:
- FETCH: `memread`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=11.
  - Stays in FETCH while `mem_ready`=0.
  - On `mem_ready`=1, that same cycle asserts `irwrite`=1 and `pcwrite`=1 (pcsrc=00), then goes to DECODE.
- DECODE: `alusrca`=0, `alusrcb`=11, `aluop`=11 (computes the branch target into ALUOut). Next state by opcode:
  - lw or sw: MEMADR.
  - R-type: EXECUTE.
  - beq: BRANCH.
  - addi or slti: IEXEC.
  - j: JUMP.
  - illegal: HALT.
- MEMADR: `alusrca`=1, `alusrcb`=10, `aluop`=11. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: `memread`=1, `iord`=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: `regwrite`=1, `regdst`=0, `memtoreg`=1. Goes to FETCH.
- MEMWR: `memwrite`=1, `iord`=1. Holds until `mem_ready`, then goes to FETCH.
- EXECUTE: `alusrca`=1, `alusrcb`=00, `aluop`=00. Goes to ALUWB.
- ALUWB: `regwrite`=1, `regdst`=1. Goes to FETCH.
- BRANCH: `alusrca`=1, `alusrcb`=00, `aluop`=10, `branch`=1, `pcsrc`=01. Goes to FETCH.
- IEXEC: `alusrca`=1, `alusrcb`=10; `aluop`=11 for addi, 01 for slti. Goes to IWB.
- IWB: `regwrite`=1, `regdst`=0, `memtoreg`=0. Goes to FETCH.
- JUMP: `pcwrite`=1, `pcsrc`=10. Goes to FETCH.
- HALT: `halted`=1 and all strobes are 0. The FSM stays here until reset.

Retired-instruction counter (`instret`):
- Increments by 1 on every transition into FETCH from MEMWB, MEMWR (on its ready cycle), ALUWB, BRANCH, IWB or JUMP.
- Wraps from 0xFFFF to 0x0000.
- Never increments in HALT.

## Timing
- Reset: while `reset`=1, all outputs are forced to 0, including `halted`. On the next edge, state = FETCH and `instret` = 0.
- Reset takes priority over every transition, including mid-instruction and in HALT. A memory access in progress is abandoned with no further strobe.
- Minimum cycles per instruction, with `mem_ready`=1 on first request:
  - lw: 5.
  - sw, R-type, addi, slti: 4.
  - beq, j: 3.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Strobes and addresses are held constant while stalled.
- `irwrite` and `pcwrite` in FETCH are single-cycle pulses, asserted only in the `mem_ready`=1 cycle.
- `pcen` is combinational in `zero`. In BRANCH, `pcen` = `zero`.
- `mem_ready` is ignored in every state except FETCH, MEMRD and MEMWR.

## Test plan
- Reset, then one R-type (opcode 0000) with `mem_ready` held 1 → states FETCH, DECODE, EXECUTE, ALUWB, back to FETCH; `aluop`=00 in EXECUTE; `regwrite`=1 and `regdst`=1 in ALUWB; `instret`=1.
- lw with `mem_ready`=0 for 3 cycles in MEMRD → `memread`=1 and `iord`=1 are held for 4 cycles; 8 cycles total; `memtoreg`=1 in MEMWB.
- beq with `zero`=1, then beq with `zero`=0 → `pcen`=1 in BRANCH for the first, `pcen`=0 for the second; `aluop`=10 in both; 3 cycles each.
- slti then addi → `aluop`=01, then 11, in IEXEC; `alusrcb`=10; `regdst`=0 in IWB; `instret` advances by 2.
- Opcode 1111 → HALT with `halted`=1 and all strobes 0 for 20 cycles; `instret` unchanged; assert `reset` → all outputs 0, then FETCH with `instret`=0.
- Assert `reset` during MEMWR with `mem_ready`=0 → `memwrite` drops to 0 while `reset`=1 and the next state is FETCH; preload `instret`=0xFFFF and retire one more instruction → `instret`=0x0000.
